me_sad_engine: RTL and testbench

Parametrised full-search block-matching engine for motion estimation. It holds one current block (BLK_W×BLK_W pixels) and one search window (SRCH_W×SRCH_W pixels) in internal register memories, loaded through write ports. On `start_i` it evaluates every candidate offset in raster order using LANES absolute-difference lanes per cycle, then reports the minimum SAD and its offset. It replaces the fixed 16/32/8-bit accelerator core with a configurable, self-reporting one.

---
 rtl/me_pkg.sv | 22 ++
 rtl/me_sad_lanes.sv | 31 +++
 rtl/me_sad_engine.sv | 191 +++++++++++++++++++
 tb/tb_me_sad_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and width helpers for the block-matching motion-estimation engine.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } me_state_e;

  // Wide enough for the worst-case block SAD: blk_w^2 * (2^pix_w - 1).
  function automatic int sad_width(input int pix_w, input int blk_w);
    return pix_w + $clog2(blk_w * blk_w);
  endfunction

  function automatic int pos_width(input int srch_w, input int blk_w);
    int pos_n;
    pos_n = srch_w - blk_w + 1;
    return (pos_n > 1) ? $clog2(pos_n) : 1;
  endfunction

endpackage

// File: rtl/me_sad_lanes.sv
// Combinational LANES-wide absolute-difference unit with a summing tree.
module me_sad_lanes
  import me_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  localparam int SUM_W = PIX_W + $clog2(LANES) + 1
) (
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] srch_pix,
  output logic [SUM_W-1:0]       sum
);

  logic [PIX_W-1:0] a;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] d;

  always_comb begin
    sum = '0;
    a   = '0;
    b   = '0;
    d   = '0;
    for (int l = 0; l < LANES; l++) begin
      a   = cur_pix[l*PIX_W +: PIX_W];
      b   = srch_pix[l*PIX_W +: PIX_W];
      d   = (a > b) ? (a - b) : (b - a);
      sum = sum + SUM_W'(d);
    end
  end

endmodule

// File: rtl/me_sad_engine.sv
// Full-search SAD block matcher; define ME_EARLY_TERM_EN to abandon candidates that cannot win.
module me_sad_engine
  import me_pkg::*;
#(
  parameter int BLK_W  = 16,
  parameter int SRCH_W = 32,
  parameter int PIX_W  = 8,
  parameter int LANES  = 4,
  localparam int SAD_W = sad_width(PIX_W, BLK_W),
  localparam int POS_W = pos_width(SRCH_W, BLK_W),
  localparam int CA_W  = $clog2(BLK_W * BLK_W),
  localparam int SA_W  = $clog2(SRCH_W * SRCH_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             curr_mem_we_i,
  input  logic [CA_W-1:0]  curr_mem_waddr_i,
  input  logic [PIX_W-1:0] curr_mem_wdata_i,
  input  logic             search_mem_we_i,
  input  logic [SA_W-1:0]  search_mem_waddr_i,
  input  logic [PIX_W-1:0] search_mem_wdata_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [POS_W-1:0] best_x_o,
  output logic [POS_W-1:0] best_y_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start_i is taken only while idle (busy_o=0, finish_o=0); finish_o pulses
  // once when the result is final, and best_* hold that result until the next start.

  localparam int NPIX  = BLK_W * BLK_W;
  localparam int NSRCH = SRCH_W * SRCH_W;
  localparam int POS_N = SRCH_W - BLK_W + 1;
  localparam int RC_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int LS_W  = PIX_W + $clog2(LANES) + 1;

  logic [PIX_W-1:0] curr_mem   [NPIX];
  logic [PIX_W-1:0] search_mem [NSRCH];

  me_state_e        state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d, x_adv, y_adv;
  logic [RC_W-1:0]  row_q, row_d, col_q, col_d, row_adv, col_adv;
  logic [SAD_W-1:0] accum_q, accum_d, accum_nxt;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [POS_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
  logic             best_valid_q, best_valid_d;
  logic             last_step, last_pos;

  logic [LANES*PIX_W-1:0] cur_vec, srch_vec;
  logic [LS_W-1:0]        lane_sum;

  // Memories load only while idle so a running search sees a stable image.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && curr_mem_we_i)
      curr_mem[curr_mem_waddr_i] <= curr_mem_wdata_i;
    if (state_q == ST_IDLE && search_mem_we_i)
      search_mem[search_mem_waddr_i] <= search_mem_wdata_i;
  end

  always_comb begin
    cur_vec  = '0;
    srch_vec = '0;
    for (int l = 0; l < LANES; l++) begin
      cur_vec[l*PIX_W +: PIX_W] =
        curr_mem[CA_W'(int'(row_q) * BLK_W + int'(col_q) + l)];
      srch_vec[l*PIX_W +: PIX_W] =
        search_mem[SA_W'((int'(y_q) + int'(row_q)) * SRCH_W + int'(x_q) + int'(col_q) + l)];
    end
  end

  me_sad_lanes #(.PIX_W(PIX_W), .LANES(LANES)) u_lanes (
    .cur_pix  (cur_vec),
    .srch_pix (srch_vec),
    .sum      (lane_sum)
  );

  assign accum_nxt = accum_q + SAD_W'(lane_sum);
  assign last_step = (row_q == RC_W'(BLK_W - 1)) && (col_q == RC_W'(BLK_W - LANES));
  assign last_pos  = (x_q == POS_W'(POS_N - 1)) && (y_q == POS_W'(POS_N - 1));

  always_comb begin
    x_adv = x_q + POS_W'(1);
    y_adv = y_q;
    if (x_q == POS_W'(POS_N - 1)) begin
      x_adv = '0;
      y_adv = y_q + POS_W'(1);
    end
    col_adv = col_q + RC_W'(LANES);
    row_adv = row_q;
    if (col_q == RC_W'(BLK_W - LANES)) begin
      col_adv = '0;
      row_adv = row_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      accum_q      <= '0;
      best_sad_q   <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      col_q        <= col_d;
      accum_q      <= accum_d;
      best_sad_q   <= best_sad_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_valid_q <= best_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_d        = row_q;
    col_d        = col_q;
    accum_d      = accum_q;
    best_sad_d   = best_sad_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_valid_d = best_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_CALC;
          x_d          = '0;
          y_d          = '0;
          row_d        = '0;
          col_d        = '0;
          accum_d      = '0;
          best_valid_d = 1'b0;
        end
      end
      ST_CALC: begin
        accum_d = accum_nxt;
        row_d   = row_adv;
        col_d   = col_adv;
        if (last_step) state_d = ST_CMP;
`ifdef ME_EARLY_TERM_EN
        // A partial sum already at or above the best can never win a strict compare.
        if (best_valid_q && accum_nxt >= best_sad_q) begin
          accum_d = '0;
          row_d   = '0;
          col_d   = '0;
          x_d     = x_adv;
          y_d     = y_adv;
          state_d = last_pos ? ST_DONE : ST_CALC;
        end
`endif
      end
      ST_CMP: begin
        if (!best_valid_q || accum_q < best_sad_q) begin
          best_sad_d   = accum_q;
          best_x_d     = x_q;
          best_y_d     = y_q;
          best_valid_d = 1'b1;
        end
        accum_d = '0;
        row_d   = '0;
        col_d   = '0;
        x_d     = x_adv;
        y_d     = y_adv;
        state_d = last_pos ? ST_DONE : ST_CALC;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q == ST_CALC) || (state_q == ST_CMP);
  assign finish_o    = (state_q == ST_DONE);
  assign best_sad_o  = best_sad_q;
  assign best_x_o    = best_x_q;
  assign best_y_o    = best_y_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_me_sad_engine.sv
// Bench for me_sad_engine: three parameterisations checked against a full-search reference model.
module tb_me_sad_engine;

  localparam int M_LAT = 81 * 17;
  localparam int O_LAT = 9;
  localparam int B_LAT = 289 * 65;
  localparam int M_W   = 14 + 4 + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [M_W-1:0] exp_q[$];

  int g_cur  [256];
  int g_srch [1024];

  // mid instance: 8x8 block, 16x16 window, 4 lanes
  logic       m_start, m_cwe, m_swe, m_busy, m_finish;
  logic [5:0] m_caddr;
  logic [7:0] m_cdata, m_saddr, m_sdata;
  logic [13:0] m_sad;
  logic [3:0] m_x, m_y;
  logic [1:0] m_state;

  // single-candidate instance
  logic       o_start, o_cwe, o_swe, o_busy, o_finish;
  logic [5:0] o_caddr, o_saddr;
  logic [7:0] o_cdata, o_sdata;
  logic [13:0] o_sad;
  logic       o_x, o_y;
  logic [1:0] o_state;

  // default-parameter instance
  logic       b_start, b_cwe, b_swe, b_busy, b_finish;
  logic [7:0] b_caddr, b_cdata, b_sdata;
  logic [9:0] b_saddr;
  logic [15:0] b_sad;
  logic [4:0] b_x, b_y;
  logic [1:0] b_state;

  me_sad_engine #(.BLK_W(8), .SRCH_W(16), .PIX_W(8), .LANES(4)) u_mid (
    .clk_i(clk), .rst_i(rst), .start_i(m_start),
    .curr_mem_we_i(m_cwe), .curr_mem_waddr_i(m_caddr), .curr_mem_wdata_i(m_cdata),
    .search_mem_we_i(m_swe), .search_mem_waddr_i(m_saddr), .search_mem_wdata_i(m_sdata),
    .busy_o(m_busy), .finish_o(m_finish), .best_sad_o(m_sad),
    .best_x_o(m_x), .best_y_o(m_y), .dbg_state_o(m_state)
  );

  me_sad_engine #(.BLK_W(8), .SRCH_W(8), .PIX_W(8), .LANES(8)) u_one (
    .clk_i(clk), .rst_i(rst), .start_i(o_start),
    .curr_mem_we_i(o_cwe), .curr_mem_waddr_i(o_caddr), .curr_mem_wdata_i(o_cdata),
    .search_mem_we_i(o_swe), .search_mem_waddr_i(o_saddr), .search_mem_wdata_i(o_sdata),
    .busy_o(o_busy), .finish_o(o_finish), .best_sad_o(o_sad),
    .best_x_o(o_x), .best_y_o(o_y), .dbg_state_o(o_state)
  );

  me_sad_engine u_big (
    .clk_i(clk), .rst_i(rst), .start_i(b_start),
    .curr_mem_we_i(b_cwe), .curr_mem_waddr_i(b_caddr), .curr_mem_wdata_i(b_cdata),
    .search_mem_we_i(b_swe), .search_mem_waddr_i(b_saddr), .search_mem_wdata_i(b_sdata),
    .busy_o(b_busy), .finish_o(b_finish), .best_sad_o(b_sad),
    .best_x_o(b_x), .best_y_o(b_y), .dbg_state_o(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exhaustive search straight from the matching rule: lowest SAD, earliest raster offset on ties.
  function automatic void ref_full(input int bw, input int sw,
                                   output int sad, output int bx, output int by);
    int pn, s, d;
    pn = sw - bw + 1;
    sad = -1; bx = 0; by = 0;
    for (int y = 0; y < pn; y++)
      for (int x = 0; x < pn; x++) begin
        s = 0;
        for (int r = 0; r < bw; r++)
          for (int c = 0; c < bw; c++) begin
            d = g_cur[r*bw + c] - g_srch[(y + r)*sw + x + c];
            s += (d < 0) ? -d : d;
          end
        if (sad < 0 || s < sad) begin
          sad = s; bx = x; by = y;
        end
      end
  endfunction

  task automatic fill(input int cur_mode, input int srch_mode);
    for (int i = 0; i < 256; i++)  g_cur[i]  = (cur_mode < 0) ? $urandom_range(0, 255) : cur_mode;
    for (int i = 0; i < 1024; i++) g_srch[i] = (srch_mode < 0) ? $urandom_range(0, 255) : srch_mode;
  endtask

  task automatic m_load();
    for (int i = 0; i < 256; i++) begin
      m_swe = 1'b1; m_saddr = 8'(i); m_sdata = 8'(g_srch[i]);
      m_cwe = (i < 64); m_caddr = 6'(i); m_cdata = 8'(g_cur[i % 64]);
      @(posedge clk); #1;
    end
    m_swe = 1'b0; m_cwe = 1'b0;
  endtask

  task automatic m_expect();
    int s, x, y;
    ref_full(8, 16, s, x, y);
    exp_q.push_back({14'(s), 4'(x), 4'(y)});
  endtask

  task automatic m_run(input bit inject, input string tag, output int cyc);
    logic [M_W-1:0] e;
    @(posedge clk); #1 m_start = 1'b1;
    @(posedge clk); #1 m_start = 1'b0;
    cyc = 0;
    check({tag, "_busy"}, 32'(m_busy), 1);
    while (!m_finish && cyc < 4000) begin
      if (inject && cyc == 5) begin
        m_start = 1'b1;
        m_cwe = 1'b1; m_caddr = 6'($urandom); m_cdata = 8'($urandom);
        m_swe = 1'b1; m_saddr = 8'($urandom); m_sdata = 8'($urandom);
      end
      if (inject && cyc == 6) begin
        m_start = 1'b0; m_cwe = 1'b0; m_swe = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_finish"}, 32'(m_finish), 1);
    check({tag, "_busy_done"}, 32'(m_busy), 0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sad"}, 32'(m_sad), 32'(e[21:8]));
      check({tag, "_x"}, 32'(m_x), 32'(e[7:4]));
      check({tag, "_y"}, 32'(m_y), 32'(e[3:0]));
    end
`ifdef ME_EARLY_TERM_EN
    check({tag, "_lat_le"}, 32'(cyc <= M_LAT), 1);
`else
    check({tag, "_lat"}, cyc, M_LAT);
`endif
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(m_finish), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s, x, y;
    m_start = 0; m_cwe = 0; m_swe = 0; m_caddr = 0; m_cdata = 0; m_saddr = 0; m_sdata = 0;
    o_start = 0; o_cwe = 0; o_swe = 0; o_caddr = 0; o_cdata = 0; o_saddr = 0; o_sdata = 0;
    b_start = 0; b_cwe = 0; b_swe = 0; b_caddr = 0; b_cdata = 0; b_saddr = 0; b_sdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(m_busy), 0);
    check("rst_finish", 32'(m_finish), 0);
    check("rst_sad", 32'(m_sad), 0);
    check("rst_x", 32'(m_x), 0);
    check("rst_y", 32'(m_y), 0);
    check("rst_big_sad", 32'(b_sad), 0);

    for (int t = 0; t < 3; t++) begin
      fill(-1, -1); m_load(); m_expect(); m_run(1'b0, "rand", cyc);
    end

    fill(0, 0); m_load(); m_expect(); m_run(1'b0, "zero", cyc);
    check("zero_sad_const", 32'(m_sad), 0);

    fill(0, 255); m_load(); m_expect(); m_run(1'b0, "max", cyc);
    check("max_sad_const", 32'(m_sad), 64 * 255);

    fill(-1, -1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g_cur[r*8 + c] = g_srch[(7 + r)*16 + 5 + c];
    m_load(); m_expect(); m_run(1'b0, "copy", cyc);
    check("copy_sad_const", 32'(m_sad), 0);
    check("copy_x_const", 32'(m_x), 5);
    check("copy_y_const", 32'(m_y), 7);
`ifdef ME_EARLY_TERM_EN
    check("copy_faster", 32'(cyc < M_LAT), 1);
`endif

    fill(-1, -1); m_load(); m_expect(); m_run(1'b1, "busy_ign", cyc);

    // Abort mid-search, then rerun on the retained memory contents.
    fill(-1, -1); m_load();
    @(posedge clk); #1 m_start = 1'b1;
    @(posedge clk); #1 m_start = 1'b0;
    repeat (999) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(m_busy), 0);
    check("abort_finish", 32'(m_finish), 0);
    check("abort_sad", 32'(m_sad), 0);
    check("abort_x", 32'(m_x), 0);
    check("abort_y", 32'(m_y), 0);
    check("abort_state", 32'(m_state), 0);
    rst = 1'b0;
    m_expect(); m_run(1'b0, "rerun", cyc);

    // Single-candidate geometry.
    fill(-1, -1);
    for (int i = 0; i < 64; i++) begin
      o_cwe = 1'b1; o_caddr = 6'(i); o_cdata = 8'(g_cur[i]);
      o_swe = 1'b1; o_saddr = 6'(i); o_sdata = 8'(g_srch[i]);
      @(posedge clk); #1;
    end
    o_cwe = 1'b0; o_swe = 1'b0;
    ref_full(8, 8, s, x, y);
    @(posedge clk); #1 o_start = 1'b1;
    @(posedge clk); #1 o_start = 1'b0;
    cyc = 0;
    while (!o_finish && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("one_lat", cyc, O_LAT);
    check("one_sad", 32'(o_sad), 32'(s));
    check("one_x", 32'(o_x), 0);
    check("one_y", 32'(o_y), 0);

    // Default geometry: flat block against saturated window.
    fill(0, 255);
    for (int i = 0; i < 1024; i++) begin
      b_swe = 1'b1; b_saddr = 10'(i); b_sdata = 8'(g_srch[i]);
      b_cwe = (i < 256); b_caddr = 8'(i); b_cdata = 8'(g_cur[i % 256]);
      @(posedge clk); #1;
    end
    b_swe = 1'b0; b_cwe = 1'b0;
    ref_full(16, 32, s, x, y);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 0;
    while (!b_finish && cyc < 25000) begin
      @(posedge clk); #1; cyc++;
    end
    check("big_finish", 32'(b_finish), 1);
`ifdef ME_EARLY_TERM_EN
    check("big_lat_le", 32'(cyc <= B_LAT), 1);
`else
    check("big_lat", cyc, B_LAT);
`endif
    check("big_sad", 32'(b_sad), 32'(s));
    check("big_sad_const", 32'(b_sad), 65280);
    check("big_x", 32'(b_x), 32'(x));
    check("big_y", 32'(b_y), 32'(y));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
